// File: rtl/apb_master.sv
// apb_master: single-command APB requester with an optional ACCESS-phase timeout.
// Commands arrive on a valid/ready port; completions return on a one-cycle response strobe.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              expire;
  // expire marks the last permitted wait cycle; PREADY on that same edge still completes normally
  assign expire    = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign cmd_ready = state_q == IDLE;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d   = SETUP;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        paddr_d   = cmd_addr;
        pwrite_d  = cmd_write;
        pwdata_d  = cmd_wdata;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: if (PREADY) begin
        state_d     = IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = PSLVERR;
        rsp_rdata_d = pwrite_q ? rsp_rdata_q : PRDATA;
      end else if (expire) begin
        state_d     = IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end else begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: random and directed commands against a transaction-timeline model of the requester,
// with a memory-backed completer whose wait states and errors are planned per command.
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 6;
  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            wt;
    logic          e;
  } cmd_t;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;
  int errs = 0, checks = 0;
  bit chk_en = 1'b0;
  cmd_t cmd_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  // model: a transfer accepted at edge 0 completes at edge m_end; PSEL spans edges 0..m_end-1
  bit m_busy = 1'b0, m_rsp = 1'b0, m_abort = 1'b0;
  int m_n = 0, m_end = 0, m_wt = 0;
  logic m_write = 1'b0, m_err_plan = 1'b0, m_rsp_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_rsp = 1'b0; m_addr = '0; m_write = 1'b0;
    m_wdata = '0; m_rdata = '0; m_rsp_err = 1'b0;
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int wt, input logic e);
    cmd_t c;
    c.w = w; c.a = a; c.d = d; c.wt = wt; c.e = e;
    cmd_q.push_back(c);
  endtask

  // drive one cycle of inputs, advance one edge, update the model, settle 1 time unit after the edge
  task automatic step();
    PREADY  = 1'($urandom_range(0, 1));
    PSLVERR = 1'($urandom_range(0, 1));
    PRDATA  = $urandom;
    if (m_busy && m_n >= 1) begin
      PREADY = (m_n - 1 == m_wt);
      if (PREADY) begin
        PSLVERR = m_err_plan;
        if (!m_write) PRDATA = slave_rd(m_addr);
      end
    end
    if (cmd_q.size() > 0) begin
      cmd_valid = 1'b1; cmd_write = cmd_q[0].w; cmd_addr = cmd_q[0].a; cmd_wdata = cmd_q[0].d;
    end else begin
      cmd_valid = 1'b0; cmd_write = 1'($urandom_range(0, 1)); cmd_addr = $urandom; cmd_wdata = $urandom;
    end
    @(posedge PCLK);
    m_rsp = 1'b0;
    if (!PRESETn) model_reset();
    else if (m_busy) begin
      m_n++;
      if (m_n == m_end) begin
        m_busy = 1'b0;
        m_rsp = 1'b1;
        m_rsp_err = m_abort | PSLVERR;
        if (m_abort) m_rdata = '0;
        else if (!m_write) m_rdata = PRDATA;
        if (!m_abort && m_write && !PSLVERR) mem[m_addr] = m_wdata;
      end
    end else if (cmd_valid) begin
      m_busy = 1'b1; m_n = 0;
      m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
      m_wt = cmd_q[0].wt; m_err_plan = cmd_q[0].e;
      m_abort = m_wt >= TO;
      m_end = (m_abort ? TO - 1 : m_wt) + 2;
      void'(cmd_q.pop_front());
    end
    #1;
  endtask

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("psel", PSEL, m_busy);
      chk("penable", PENABLE, m_busy && m_n >= 1);
      chk("rsp_valid", rsp_valid, m_rsp);
      chk("paddr", PADDR, m_addr);
      chk("pwrite", PWRITE, m_write);
      chk("pwdata", PWDATA, m_wdata);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      if (m_rsp) chk("rsp_err", rsp_err, m_rsp_err);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, pen, r, wt;
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    PRESETn = 1'b1;
    chk_en = 1'b1;
    push(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    step(); chk("t1_setup_psel", PSEL, 1); chk("t1_setup_penable", PENABLE, 0);
    step(); chk("t1_access_penable", PENABLE, 1);
    step(); chk("t1_rsp_valid", rsp_valid, 1); chk("t1_rsp_err", rsp_err, 0); chk("t1_psel_off", PSEL, 0);
    push(1'b0, 32'h10, '0, 0, 1'b0);
    repeat (3) step();
    chk("t2_rdata", rsp_rdata, 32'hDEADBEEF); chk("t2_rsp_err", rsp_err, 0);
    push(1'b1, 32'h24, 32'h12345678, 5, 1'b1);
    step(); step();
    repeat (5) begin
      step();
      chk("t3_paddr", PADDR, 32'h24); chk("t3_pwdata", PWDATA, 32'h12345678); chk("t3_no_rsp", rsp_valid, 0);
    end
    step(); chk("t3_rsp_valid", rsp_valid, 1); chk("t3_rsp_err", rsp_err, 1);
    step(); chk("t3_single_rsp", rsp_valid, 0);
    push(1'b0, 32'h40, '0, 99, 1'b0);
    cnt = 0; pen = 0;
    do begin
      step(); cnt++;
      if (PENABLE) pen++;
    end while (!rsp_valid && cnt < 50);
    chk("t4_edges", cnt, TO + 2); chk("t4_access_cycles", pen, TO);
    chk("t4_rsp_err", rsp_err, 1); chk("t4_rdata", rsp_rdata, 0); chk("t4_cmd_ready", cmd_ready, 1);
    push(1'b0, 32'h10, '0, TO - 1, 1'b0);
    repeat (TO + 2) step();
    chk("t4b_rsp_valid", rsp_valid, 1); chk("t4b_rsp_err", rsp_err, 0); chk("t4b_rdata", rsp_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) push(1'b1, 32'h100 + 4 * i, 32'hA000 + i, 0, 1'b0);
    cnt = 0;
    repeat (9) begin
      step();
      if (rsp_valid) cnt++;
    end
    chk("t5_rsp_count", cnt, 3); chk("t5_last_rsp", rsp_valid, 1); chk("t5_paddr", PADDR, 32'h108);
    push(1'b1, 32'h200, 32'hCAFEF00D, 20, 1'b0);
    step(); step(); step();
    PRESETn = 1'b0;
    #1;
    chk("t6_psel_async", PSEL, 0); chk("t6_penable_async", PENABLE, 0);
    model_reset();
    step(); step();
    chk("t6_no_rsp", rsp_valid, 0);
    PRESETn = 1'b1;
    push(1'b0, 32'h24, '0, 1, 1'b0);
    repeat (4) step();
    chk("t6_after_rsp", rsp_valid, 1); chk("t6_rdata", rsp_rdata, 32'hFFFFFFDB);
    for (int i = 0; i < 400; i++) begin
      if (cmd_q.size() == 0 && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        wt = r < 6 ? $urandom_range(0, 2) : r < 8 ? TO - 1 + $urandom_range(0, 1) : $urandom_range(0, 12);
        push(1'($urandom_range(0, 1)), 32'h1000 + 4 * $urandom_range(0, 7), $urandom, wt,
             1'($urandom_range(0, 3) == 0));
      end
      step();
    end
    cnt = 0;
    while ((m_busy || cmd_q.size() > 0) && cnt < 100) begin
      step(); cnt++;
    end
    chk("drain_cmd_ready", cmd_ready, 1);
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
